spike_generator_bank: RTL and testbench

- Time-multiplexed bank of up to 2**NGENS_LOG2 periodic spike generators.
- Each generator has a programmable period, an initial phase, a tag and a sign.
- On every FPGA time-unit pulse from the time manager, the bank sweeps generators 0..gens_used and emits one tag/count word for each generator that is due.
- Output feeds the tag/count merge path toward BD.
- Successor to the fixed-width generator: widths, count polarity, backpressure and missed-tick detection are all parametrised/handled.

---
 rtl/spike_generator_bank_if.sv | 34 +++
 rtl/spike_generator_bank.sv | 124 ++++++++++++
 tb/tb_spike_generator_bank.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_generator_bank_if.sv
// rtl/spike_generator_bank_if.sv - program and tag/count output handshake channels of the spike generator bank
interface spike_generator_bank_if #(
    parameter int NGENS_LOG2 = 8,
    parameter int NPERIOD    = 16,
    parameter int NTAG       = 11,
    parameter int NCT        = 9
);
    logic [NGENS_LOG2-1:0] prog_gen_idx;
    logic [NPERIOD-1:0]    prog_period;
    logic [NPERIOD-1:0]    prog_ticks;
    logic [NTAG-1:0]       prog_tag;
    logic                  prog_sign;
    logic                  prog_v;
    logic                  prog_a;
    logic [NTAG-1:0]       out_tag;
    logic [NCT-1:0]        out_ct;
    logic                  out_v;
    logic                  out_a;

    // master: host that programs generators and consumes the emitted words
    modport master (
        output prog_gen_idx, prog_period, prog_ticks, prog_tag, prog_sign, prog_v,
        input  prog_a,
        input  out_tag, out_ct, out_v,
        output out_a
    );

    modport slave (
        input  prog_gen_idx, prog_period, prog_ticks, prog_tag, prog_sign, prog_v,
        output prog_a,
        output out_tag, out_ct, out_v,
        input  out_a
    );
endinterface

// File: rtl/spike_generator_bank.sv
// rtl/spike_generator_bank.sv - time-multiplexed bank of periodic spike generators emitting tag/count words
module spike_generator_bank #(
    parameter int NGENS_LOG2 = 8,
    parameter int NPERIOD    = 16,
    parameter int NTAG       = 11,
    parameter int NCT        = 9
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     time_unit_pulse,
    input  logic [NGENS_LOG2-1:0]    gens_used,
    input  logic [2**NGENS_LOG2-1:0] gens_en,
    output logic                     missed_tick,
    spike_generator_bank_if.slave    bus
);
    localparam int NGENS = 2**NGENS_LOG2;
    localparam logic [NGENS_LOG2-1:0] IDX_ONE = 1;

    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

    state_t                state_q;
    logic [NGENS_LOG2-1:0] idx_q;
    logic                  pending_q;
    logic                  missed_q;
    logic                  out_v_q;
    logic [NTAG-1:0]       out_tag_q;
    logic [NCT-1:0]        out_ct_q;

    logic [NPERIOD-1:0]    period_q [NGENS];
    logic [NPERIOD-1:0]    ticks_q  [NGENS];
    logic [NTAG-1:0]       tag_q    [NGENS];
    logic                  sign_q   [NGENS];

    logic                  prog_fire;
    logic                  gen_active;
    logic                  sweep_end;
    logic [NPERIOD-1:0]    cur_period;
    logic [NPERIOD-1:0]    cur_ticks;

    assign cur_period = period_q[idx_q];
    assign cur_ticks  = ticks_q[idx_q];
    assign gen_active = gens_en[idx_q] && (cur_period != '0);
    // >= so that a gens_used lowered mid-sweep still terminates it
    assign sweep_end  = (idx_q >= gens_used);

    assign bus.prog_a  = reset_n && (state_q == IDLE) && !pending_q && !time_unit_pulse;
    assign prog_fire   = bus.prog_v && bus.prog_a;
    assign bus.out_v   = out_v_q;
    assign bus.out_tag = out_tag_q;
    assign bus.out_ct  = out_ct_q;
    assign missed_tick = missed_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            missed_q  <= 1'b0;
            out_v_q   <= 1'b0;
            out_tag_q <= '0;
            out_ct_q  <= '0;
            for (int i = 0; i < NGENS; i++) begin
                period_q[i] <= '0;
                ticks_q[i]  <= '0;
                tag_q[i]    <= '0;
                sign_q[i]   <= 1'b0;
            end
        end else begin
            // one pulse may be queued behind a running sweep; a further one is lost
            if (time_unit_pulse) begin
                if (pending_q) begin
                    missed_q <= 1'b1;
                end else if (state_q != IDLE) begin
                    pending_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (time_unit_pulse || pending_q) begin
                        state_q   <= SCAN;
                        idx_q     <= '0;
                        pending_q <= 1'b0;
                    end else if (prog_fire) begin
                        period_q[bus.prog_gen_idx] <= bus.prog_period;
                        ticks_q[bus.prog_gen_idx]  <= bus.prog_ticks;
                        tag_q[bus.prog_gen_idx]    <= bus.prog_tag;
                        sign_q[bus.prog_gen_idx]   <= bus.prog_sign;
                    end
                end
                SCAN: begin
                    if (gen_active && (cur_ticks == '0)) begin
                        ticks_q[idx_q] <= cur_period - NPERIOD'(1);
                        out_tag_q      <= tag_q[idx_q];
                        out_ct_q       <= sign_q[idx_q] ? '1 : NCT'(1);
                        out_v_q        <= 1'b1;
                        state_q        <= EMIT;
                    end else begin
                        if (gen_active) begin
                            ticks_q[idx_q] <= cur_ticks - NPERIOD'(1);
                        end
                        if (sweep_end) begin
                            state_q <= IDLE;
                        end else begin
                            idx_q <= idx_q + IDX_ONE;
                        end
                    end
                end
                EMIT: begin
                    if (bus.out_a) begin
                        out_v_q <= 1'b0;
                        if (sweep_end) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= SCAN;
                            idx_q   <= idx_q + IDX_ONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spike_generator_bank.sv
// tb/tb_spike_generator_bank.sv - directed self-checking bench for spike_generator_bank
module tb_spike_generator_bank;
    localparam int NGL = 8;
    localparam int NP  = 16;
    localparam int NT  = 11;
    localparam int NC  = 9;
    localparam int NG  = 2**NGL;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           time_unit_pulse = 1'b0;
    logic [NGL-1:0] gens_used = '0;
    logic [NG-1:0]  gens_en = '0;
    logic           missed_tick;

    spike_generator_bank_if #(.NGENS_LOG2(NGL), .NPERIOD(NP), .NTAG(NT), .NCT(NC)) bus ();

    spike_generator_bank #(.NGENS_LOG2(NGL), .NPERIOD(NP), .NTAG(NT), .NCT(NC)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .time_unit_pulse (time_unit_pulse),
        .gens_used       (gens_used),
        .gens_en         (gens_en),
        .missed_tick     (missed_tick),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [NT-1:0] wtag_q [$];
    logic [NC-1:0] wct_q  [$];

    // records each word at the negedge before the edge that completes its handshake
    always @(negedge clk) begin
        if (reset_n && bus.out_v && bus.out_a) begin
            wtag_q.push_back(bus.out_tag);
            wct_q.push_back(bus.out_ct);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse();
        time_unit_pulse = 1'b1;
        tick();
        time_unit_pulse = 1'b0;
    endtask

    task automatic prog(input int idx, input int period, input int ticks, input int tag, input bit sign);
        bit ok;
        ok = 1'b0;
        bus.prog_gen_idx = NGL'(idx);
        bus.prog_period  = NP'(period);
        bus.prog_ticks   = NP'(ticks);
        bus.prog_tag     = NT'(tag);
        bus.prog_sign    = sign;
        bus.prog_v       = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            if (bus.prog_a) ok = 1'b1;
            tick();
        end
        bus.prog_v = 1'b0;
        check("prog_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_outv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (bus.out_v) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick();
    endtask

    int base;
    int stable;
    bit ok;
    int t1_exp [9] = '{1, 1, 1, 2, 2, 2, 3, 3, 3};

    initial begin
        bus.prog_v       = 1'b0;
        bus.prog_gen_idx = '0;
        bus.prog_period  = '0;
        bus.prog_ticks   = '0;
        bus.prog_tag     = '0;
        bus.prog_sign    = 1'b0;
        bus.out_a        = 1'b1;
        tick(2);
        check("rst_out_v", 32'(bus.out_v), 32'd0);
        check("rst_out_tag", 32'(bus.out_tag), 32'd0);
        check("rst_out_ct", 32'(bus.out_ct), 32'd0);
        check("rst_missed", 32'(missed_tick), 32'd0);
        check("rst_prog_a", 32'(bus.prog_a), 32'd0);
        reset_n = 1'b1;
        tick();
        check("idle_prog_a", 32'(bus.prog_a), 32'd1);

        // period 3, phase 0: fires on pulses 1, 4, 7
        prog(0, 3, 0, 'h05, 1'b0);
        gens_used = '0;
        gens_en   = NG'(1);
        base = wtag_q.size();
        for (int k = 0; k < 9; k++) begin
            pulse();
            tick(49);
            check($sformatf("t1_words_after_pulse%0d", k + 1), 32'(wtag_q.size() - base), 32'(t1_exp[k]));
        end
        for (int i = 0; i < 3; i++) begin
            check("t1_tag", 32'(wtag_q[base + i]), 32'h05);
            check("t1_ct", 32'(wct_q[base + i]), 32'h001);
        end

        // gen 2 disabled, then enabled; negative count
        prog(0, 0, 0, 0, 1'b0);
        prog(2, 1, 0, 'h7FF, 1'b1);
        gens_used = NGL'(2);
        gens_en   = NG'(1);
        base = wtag_q.size();
        repeat (3) begin
            pulse();
            tick(20);
        end
        check("t2_disabled_words", 32'(wtag_q.size() - base), 32'd0);
        gens_en = NG'(5);
        repeat (3) begin
            pulse();
            tick(20);
        end
        check("t2_enabled_words", 32'(wtag_q.size() - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("t2_tag", 32'(wtag_q[base + i]), 32'h7FF);
            check("t2_ct", 32'(wct_q[base + i]), 32'h1FF);
        end

        // backpressure with two due generators
        do_reset();
        gens_used = NGL'(1);
        gens_en   = NG'(3);
        prog(0, 2, 0, 'h10, 1'b0);
        prog(1, 2, 0, 'h11, 1'b1);
        bus.out_a = 1'b0;
        base = wtag_q.size();
        pulse();
        wait_outv(ok);
        check("t3_out_v_seen", 32'(ok), 32'd1);
        stable = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_v && bus.out_tag == NT'('h10) && bus.out_ct == NC'(1)) stable++;
            tick();
        end
        check("t3_stable_cycles", 32'(stable), 32'd20);
        bus.out_a = 1'b1;
        tick(10);
        check("t3_words", 32'(wtag_q.size() - base), 32'd2);
        check("t3_first_tag", 32'(wtag_q[base]), 32'h10);
        check("t3_first_ct", 32'(wct_q[base]), 32'h001);
        check("t3_second_tag", 32'(wtag_q[base + 1]), 32'h11);
        check("t3_second_ct", 32'(wct_q[base + 1]), 32'h1FF);

        // three pulses during one stalled sweep
        do_reset();
        gens_used = '0;
        gens_en   = NG'(1);
        prog(0, 1, 0, 'h20, 1'b0);
        bus.out_a = 1'b0;
        base = wtag_q.size();
        pulse();
        wait_outv(ok);
        check("t4_out_v_seen", 32'(ok), 32'd1);
        pulse();
        tick();
        check("t4_missed_after_2nd", 32'(missed_tick), 32'd0);
        check("t4_prog_a_busy", 32'(bus.prog_a), 32'd0);
        pulse();
        tick();
        check("t4_missed_after_3rd", 32'(missed_tick), 32'd1);
        bus.out_a = 1'b1;
        tick(30);
        check("t4_sweep_words", 32'(wtag_q.size() - base), 32'd2);
        check("t4_missed_sticky", 32'(missed_tick), 32'd1);

        // prog_v during SCAN, then pulse colliding with prog_v in IDLE
        gens_en   = '0;
        gens_used = NGL'(200);
        pulse();
        bus.prog_gen_idx = NGL'(3);
        bus.prog_period  = NP'(1);
        bus.prog_ticks   = '0;
        bus.prog_tag     = NT'('h33);
        bus.prog_sign    = 1'b0;
        bus.prog_v       = 1'b1;
        #1;
        check("t5_prog_a_scan_early", 32'(bus.prog_a), 32'd0);
        tick(100);
        check("t5_prog_a_scan_late", 32'(bus.prog_a), 32'd0);
        tick(110);
        check("t5_prog_a_idle", 32'(bus.prog_a), 32'd1);
        time_unit_pulse = 1'b1;
        #1;
        check("t5_prog_a_pulse_wins", 32'(bus.prog_a), 32'd0);
        tick();
        time_unit_pulse = 1'b0;
        #1;
        check("t5_prog_a_sweep_started", 32'(bus.prog_a), 32'd0);
        bus.prog_v = 1'b0;
        tick(210);

        // asynchronous reset mid-EMIT
        do_reset();
        gens_used = '0;
        gens_en   = NG'(1);
        prog(0, 1, 0, 'h44, 1'b0);
        bus.out_a = 1'b0;
        pulse();
        wait_outv(ok);
        check("t6_out_v_seen", 32'(ok), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_async_out_v", 32'(bus.out_v), 32'd0);
        check("t6_async_out_tag", 32'(bus.out_tag), 32'd0);
        tick();
        reset_n   = 1'b1;
        bus.out_a = 1'b1;
        base = wtag_q.size();
        repeat (3) begin
            pulse();
            tick(20);
        end
        check("t6_silent_after_reset", 32'(wtag_q.size() - base), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
